m6800_bus_emu: RTL and testbench
================================

Name: m6800_bus_emu

Overview:
- Parametrised 6800-style synchronous bus emulator for the 68k-side CPU bus.
- Divides C7M to generate E, with programmable period and duty.
- Detects VPA-qualified cycles and drives VMA_n in the correct E slot.
- Returns M6800_DTACK_n after E falls, with an optional extra delay and clean abort handling.
- Sits beside the bus-cycle controller; its DTACK is ORed into the CPU DTACK path.

Parameters:
- E_DIV, 10: C7M cycles per E period (legal 4..16).
- E_LOW, 6: C7M cycles E is low in each period; E is high for E_DIV-E_LOW cycles (legal 1..E_DIV-1).
- VMA_SLOT, 3: e_cnt value at which a pending VPA cycle is latched (legal 0..E_LOW-2).
- DTACK_DELAY, 0: extra C7M cycles after E falls before DTACK asserts (0..7).
- SYNC_STAGES, 2: flip-flop stages on VPA_n and AS_CPU_n (legal 1..3).
- CNT_W, 4: width of e_cnt (must satisfy 2^CNT_W >= E_DIV).

Ports:
- C7M  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- VPA_n  in  1  valid peripheral address, async, active low.
- CPUSPACE  in  1  high = CPU-space (IACK) cycle; never emulated.
- AS_CPU_n  in  1  CPU address strobe, async, active low.
- E  out  1  registered E clock.
- E_RISE  out  1  one-cycle pulse coincident with the first C7M cycle of E high.
- E_FALL  out  1  one-cycle pulse coincident with the first C7M cycle of E low.
- VMA_n  out  1  valid memory address, active low.
- M6800_DTACK_n  out  1  emulated-cycle DTACK, active low.
- BUSY  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset: e_cnt=0, E=0, E_RISE=0, E_FALL=0, VMA_n=1, M6800_DTACK_n=1, BUSY=0, FSM=IDLE, sync chains=1.
- Reset is honoured on any cycle, including mid-cycle; it is not preceded by an abort sequence.
- Counter e_cnt runs 0..E_DIV-1 and wraps to 0. It is free-running and never stalls for bus activity.
- E is registered and equals 1 exactly when e_cnt is in E_LOW..E_DIV-1.
- E_RISE=1 when e_cnt==E_LOW. E_FALL=1 when e_cnt==0, except the first count after reset.
- Synchronised signals vpa_s and as_s lag their pins by SYNC_STAGES cycles.
- FSM states: IDLE, ARMED, DTWAIT, DTACK.
- IDLE:
  - Condition: e_cnt==VMA_SLOT, !vpa_s, !as_s, CPUSPACE==0.
  - Action: VMA_n<=0, go to ARMED.
  - If CPUSPACE==1, stay in IDLE with VMA_n=1 (autovector is handled elsewhere).
  - A VPA seen after VMA_SLOT waits for the next period's slot.
- ARMED:
  - On the cycle where e_cnt==E_DIV-1 (E falls next):
    - DTACK_DELAY==0: M6800_DTACK_n<=0, go to DTACK.
    - Otherwise: load the delay counter with DTACK_DELAY and go to DTWAIT.
- DTWAIT: decrement the delay counter; when it reaches 1, M6800_DTACK_n<=0 and go to DTACK.
- DTACK: hold VMA_n=0 and M6800_DTACK_n=0 until as_s==1, then both go to 1 and the FSM returns to IDLE on the same edge.
- Abort: as_s==1 or vpa_s==1 in ARMED or DTWAIT → VMA_n<=1, M6800_DTACK_n<=1, IDLE next cycle. No DTACK pulse is emitted.
- Simultaneous events:
  - Abort beats DTACK assertion when both occur on the same edge.
  - A new qualifying VPA is accepted only from IDLE. A new cycle therefore cannot start before as_s has risen.
- Worst-case VPA-to-VMA latency is SYNC_STAGES + E_DIV cycles.

Decomposition:
- Package m6800_pkg holds:
  - the FSM state enum (2-bit);
  - localparams for the default E_DIV, E_LOW and VMA_SLOT;
  - compile-time legality checks for the parameters.
- Sub-module bus_sync: SYNC_STAGES-deep flop chain with reset value 1, instantiated for VPA_n and AS_CPU_n.
- The counter and FSM stay in the top module.

Test Plan:
- Defaults, RESET held 3 cycles then released → E low for 6 cycles and high for 4, repeating. E_RISE and E_FALL are single-cycle pulses; VMA_n and M6800_DTACK_n stay 1.
- VPA_n and AS_CPU_n driven low at e_cnt=0, CPUSPACE=0 → VMA_n falls on the e_cnt=3 edge. M6800_DTACK_n falls on the e_cnt=9 edge, i.e. is low from e_cnt=0. AS_CPU_n high → both outputs return to 1 after 2 sync cycles plus 1 register cycle.
- VPA_n low at e_cnt=5 → VMA_n waits for the next period's e_cnt=3, a 9-cycle hold-off with no early VMA.
- CPUSPACE=1 with VPA_n and AS_CPU_n low for 3 E periods → VMA_n=1, M6800_DTACK_n=1, BUSY=0 throughout.
- AS_CPU_n released at e_cnt=7 while ARMED → VMA_n=1 with no DTACK pulse. A re-run with DTACK_DELAY=3 → DTACK falls 3 cycles after E_FALL.
- RESET asserted while DTACK=0 → next edge gives VMA_n=1, M6800_DTACK_n=1, E=0, e_cnt=0.

Source files
------------

// File: rtl/m6800_pkg.sv
// Shared types, defaults and parameter legality check for the 6800-style bus emulator.
package m6800_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StDtWait = 2'd2,
        StDtack  = 2'd3
    } bus_state_e;

    localparam int unsigned DefEDiv    = 10;
    localparam int unsigned DefELow    = 6;
    localparam int unsigned DefVmaSlot = 3;

    function automatic bit params_legal(input int unsigned e_div,
                                        input int unsigned e_low,
                                        input int unsigned vma_slot,
                                        input int unsigned dtack_delay,
                                        input int unsigned sync_stages,
                                        input int unsigned cnt_w);
        return (e_div >= 4) && (e_div <= 16) &&
               (e_low >= 1) && (e_low <= e_div - 1) &&
               (vma_slot + 2 <= e_low) &&
               (dtack_delay <= 7) &&
               (sync_stages >= 1) && (sync_stages <= 3) &&
               (cnt_w >= 1) && (cnt_w <= 16) &&
               ((32'd1 << cnt_w) >= e_div);
    endfunction

endpackage

// File: rtl/m6800_bus_emu_if.sv
// CPU-side pins seen by the 6800 bus emulator: VPA/AS/CPUSPACE in, E/VMA/DTACK/BUSY out.
interface m6800_bus_emu_if;

    logic VPA_n;
    logic CPUSPACE;
    logic AS_CPU_n;
    logic E;
    logic E_RISE;
    logic E_FALL;
    logic VMA_n;
    logic M6800_DTACK_n;
    logic BUSY;

    modport master (
        output VPA_n, CPUSPACE, AS_CPU_n,
        input  E, E_RISE, E_FALL, VMA_n, M6800_DTACK_n, BUSY
    );

    modport slave (
        input  VPA_n, CPUSPACE, AS_CPU_n,
        output E, E_RISE, E_FALL, VMA_n, M6800_DTACK_n, BUSY
    );

endinterface

// File: rtl/bus_sync.sv
// Flop-chain synchroniser for an active-low async pin; resets to the deasserted (1) level.
module bus_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '1;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < int'(Stages); i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/m6800_bus_emu.sv
// 6800-style synchronous bus emulator: divides C7M into E, asserts VMA_n in the E slot for
// VPA-qualified cycles and returns M6800_DTACK_n after E falls.
module m6800_bus_emu
    import m6800_pkg::*;
#(
    parameter int unsigned E_DIV       = DefEDiv,
    parameter int unsigned E_LOW       = DefELow,
    parameter int unsigned VMA_SLOT    = DefVmaSlot,
    parameter int unsigned DTACK_DELAY = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             C7M,
    input  logic             RESET,
    m6800_bus_emu_if.slave   bus
);

    if (!params_legal(E_DIV, E_LOW, VMA_SLOT, DTACK_DELAY, SYNC_STAGES, CNT_W))
    begin : g_param_check
        $error("m6800_bus_emu: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(E_DIV - 1);
    localparam logic [CNT_W-1:0] CntLow  = CNT_W'(E_LOW);
    localparam logic [CNT_W-1:0] CntSlot = CNT_W'(VMA_SLOT);
    localparam logic [2:0]       DlyLoad = 3'(DTACK_DELAY);

    logic vpa_s;
    logic as_s;

    bus_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_vpa (
        .clk_i (C7M),
        .rst_i (RESET),
        .d_i   (bus.VPA_n),
        .q_o   (vpa_s)
    );

    bus_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_as (
        .clk_i (C7M),
        .rst_i (RESET),
        .d_i   (bus.AS_CPU_n),
        .q_o   (as_s)
    );

    // E divider: flags are registered from the next count so they line up with e_cnt_q
    logic [CNT_W-1:0] e_cnt_q, e_cnt_d;
    logic             e_q, e_rise_q, e_fall_q;

    assign e_cnt_d = (e_cnt_q == CntLast) ? '0 : e_cnt_q + 1'b1;

    always_ff @(posedge C7M) begin
        if (RESET) begin
            e_cnt_q  <= '0;
            e_q      <= 1'b0;
            e_rise_q <= 1'b0;
            e_fall_q <= 1'b0;
        end else begin
            e_cnt_q  <= e_cnt_d;
            e_q      <= (e_cnt_d >= CntLow);
            e_rise_q <= (e_cnt_d == CntLow);
            e_fall_q <= (e_cnt_d == '0);
        end
    end

    bus_state_e state_q, state_d;
    logic       vma_n_q, vma_n_d;
    logic       dtack_n_q, dtack_n_d;
    logic [2:0] dly_q, dly_d;

    always_comb begin
        state_d   = state_q;
        vma_n_d   = vma_n_q;
        dtack_n_d = dtack_n_q;
        dly_d     = dly_q;
        case (state_q)
            StIdle: begin
                if ((e_cnt_q == CntSlot) && !vpa_s && !as_s && !bus.CPUSPACE) begin
                    vma_n_d = 1'b0;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // abort wins over a DTACK that would otherwise assert on this edge
                if (as_s || vpa_s) begin
                    vma_n_d   = 1'b1;
                    dtack_n_d = 1'b1;
                    state_d   = StIdle;
                end else if (e_cnt_q == CntLast) begin
                    if (DTACK_DELAY == 0) begin
                        dtack_n_d = 1'b0;
                        state_d   = StDtack;
                    end else begin
                        dly_d   = DlyLoad;
                        state_d = StDtWait;
                    end
                end
            end
            StDtWait: begin
                if (as_s || vpa_s) begin
                    vma_n_d   = 1'b1;
                    dtack_n_d = 1'b1;
                    state_d   = StIdle;
                end else if (dly_q == 3'd1) begin
                    dtack_n_d = 1'b0;
                    state_d   = StDtack;
                end else begin
                    dly_d = dly_q - 3'd1;
                end
            end
            StDtack: begin
                if (as_s) begin
                    vma_n_d   = 1'b1;
                    dtack_n_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                vma_n_d   = 1'b1;
                dtack_n_d = 1'b1;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            state_q   <= StIdle;
            vma_n_q   <= 1'b1;
            dtack_n_q <= 1'b1;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            vma_n_q   <= vma_n_d;
            dtack_n_q <= dtack_n_d;
            dly_q     <= dly_d;
        end
    end

    assign bus.E             = e_q;
    assign bus.E_RISE        = e_rise_q;
    assign bus.E_FALL        = e_fall_q;
    assign bus.VMA_n         = vma_n_q;
    assign bus.M6800_DTACK_n = dtack_n_q;
    assign bus.BUSY          = (state_q != StIdle);

endmodule

// File: tb/tb_m6800_bus_emu.sv
// Self-checking bench: two emulators (DTACK_DELAY 0 and 3) on shared pins, a cycle-level
// reference model, a latency vector table, hand-written corner sequences and random stimulus.
module tb_m6800_bus_emu;

    localparam int EDiv = 10;
    localparam int ELow = 6;
    localparam int Slot = 3;
    localparam int Sync = 2;

    logic C7M;
    logic RESET;
    logic vpa_n;
    logic as_n;
    logic cpuspace;

    int checks;
    int failures;
    bit chk_en;

    m6800_bus_emu_if bus_a ();
    m6800_bus_emu_if bus_b ();

    assign bus_a.VPA_n    = vpa_n;
    assign bus_a.AS_CPU_n = as_n;
    assign bus_a.CPUSPACE = cpuspace;
    assign bus_b.VPA_n    = vpa_n;
    assign bus_b.AS_CPU_n = as_n;
    assign bus_b.CPUSPACE = cpuspace;

    m6800_bus_emu u_dut_a (
        .C7M   (C7M),
        .RESET (RESET),
        .bus   (bus_a)
    );

    m6800_bus_emu #(
        .DTACK_DELAY (3)
    ) u_dut_b (
        .C7M   (C7M),
        .RESET (RESET),
        .bus   (bus_b)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: E phase, a queue of sampled pin history, and per-DUT bus transaction
    // bookkeeping with an absolute edge index at which DTACK is due.
    int     m_phase;
    bit     m_fall_ok;
    bit     m_active [2];
    bit     m_dtack  [2];
    longint m_due    [2];
    longint cyc;
    bit     vq [$];
    bit     aq [$];

    function automatic int dly_of(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic model_step();
        bit vs;
        bit as_s;
        if (RESET) begin
            m_phase   = 0;
            m_fall_ok = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                m_dtack[k]  = 1'b0;
            end
            vq.delete();
            aq.delete();
            for (int i = 0; i < Sync; i++) begin
                vq.push_back(1'b1);
                aq.push_back(1'b1);
            end
        end else begin
            vs   = vq[0];
            as_s = aq[0];
            for (int k = 0; k < 2; k++) begin
                if (!m_active[k]) begin
                    if (m_phase == Slot && !vs && !as_s && !cpuspace) begin
                        m_active[k] = 1'b1;
                        m_due[k]    = cyc + (EDiv - 1 - Slot) + dly_of(k);
                    end
                end else if (!m_dtack[k]) begin
                    if (vs || as_s) m_active[k] = 1'b0;
                    else if (cyc == m_due[k]) m_dtack[k] = 1'b1;
                end else if (as_s) begin
                    m_active[k] = 1'b0;
                    m_dtack[k]  = 1'b0;
                end
            end
            m_phase   = (m_phase + 1) % EDiv;
            m_fall_ok = 1'b1;
            void'(vq.pop_front());
            void'(aq.pop_front());
            vq.push_back(vpa_n);
            aq.push_back(as_n);
        end
        cyc++;
    endtask

    task automatic chk_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk_bit("a.E", bus_a.E, m_phase >= ELow);
        chk_bit("a.E_RISE", bus_a.E_RISE, m_phase == ELow);
        chk_bit("a.E_FALL", bus_a.E_FALL, (m_phase == 0) && m_fall_ok);
        chk_bit("a.VMA_n", bus_a.VMA_n, !m_active[0]);
        chk_bit("a.DTACK_n", bus_a.M6800_DTACK_n, !m_dtack[0]);
        chk_bit("a.BUSY", bus_a.BUSY, m_active[0]);
        chk_bit("b.E", bus_b.E, m_phase >= ELow);
        chk_bit("b.E_RISE", bus_b.E_RISE, m_phase == ELow);
        chk_bit("b.E_FALL", bus_b.E_FALL, (m_phase == 0) && m_fall_ok);
        chk_bit("b.VMA_n", bus_b.VMA_n, !m_active[1]);
        chk_bit("b.DTACK_n", bus_b.M6800_DTACK_n, !m_dtack[1]);
        chk_bit("b.BUSY", bus_b.BUSY, m_active[1]);
    endtask

    task automatic tick();
        @(posedge C7M);
        model_step();
        @(negedge C7M);
        if (chk_en) check_all();
    endtask

    task automatic wait_phase(int p);
        for (int n = 0; n < EDiv && m_phase != p; n++) tick();
    endtask

    typedef struct {
        string name;
        int    start_phase;
        bit    cpu;
        int    exp_vma;
        int    exp_dt_a;
        int    exp_dt_b;
        int    exp_rel;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lv, la, lb, lr;
        bit seen;

        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        cyc      = 0;
        RESET    = 1'b1;
        vpa_n    = 1'b1;
        as_n     = 1'b1;
        cpuspace = 1'b0;

        // latency counted in C7M cycles from the cycle the pins are driven low; -1 = never
        vecs[0] = '{"start_p0", 0, 1'b0, 4, 10, 13, 3};
        vecs[1] = '{"start_p1", 1, 1'b0, 3, 9, 12, 3};
        vecs[2] = '{"start_p2_missed", 2, 1'b0, 12, 18, 21, 3};
        vecs[3] = '{"start_p3_missed", 3, 1'b0, 11, 17, 20, 3};
        vecs[4] = '{"start_p5_holdoff", 5, 1'b0, 9, 15, 18, 3};
        vecs[5] = '{"cpuspace", 0, 1'b1, -1, -1, -1, 1};

        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (25) tick();

        foreach (vecs[i]) begin
            wait_phase(vecs[i].start_phase);
            vpa_n    = 1'b0;
            as_n     = 1'b0;
            cpuspace = vecs[i].cpu;
            lv = -1; la = -1; lb = -1;
            for (int n = 1; n <= 40; n++) begin
                tick();
                if (lv < 0 && bus_a.VMA_n == 1'b0) lv = n;
                if (la < 0 && bus_a.M6800_DTACK_n == 1'b0) la = n;
                if (lb < 0 && bus_b.M6800_DTACK_n == 1'b0) lb = n;
                if (lb >= 0) break;
            end
            chk_int({vecs[i].name, " vma_latency"}, lv, vecs[i].exp_vma);
            chk_int({vecs[i].name, " dtack_latency_d0"}, la, vecs[i].exp_dt_a);
            chk_int({vecs[i].name, " dtack_latency_d3"}, lb, vecs[i].exp_dt_b);
            vpa_n    = 1'b1;
            as_n     = 1'b1;
            cpuspace = 1'b0;
            lr = -1;
            for (int n = 1; n <= 10; n++) begin
                tick();
                if (lr < 0 && bus_a.VMA_n && bus_a.M6800_DTACK_n && !bus_a.BUSY &&
                    bus_b.VMA_n && bus_b.M6800_DTACK_n && !bus_b.BUSY) lr = n;
                if (lr >= 0) break;
            end
            chk_int({vecs[i].name, " release_latency"}, lr, vecs[i].exp_rel);
            repeat (3) tick();
        end

        // AS released while ARMED: abort with no DTACK pulse on either instance
        wait_phase(0);
        vpa_n = 1'b0;
        as_n  = 1'b0;
        wait_phase(7);
        as_n = 1'b1;
        wait_phase(0);
        chk_bit("abort vma_a", bus_a.VMA_n, 1'b1);
        chk_bit("abort vma_b", bus_b.VMA_n, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (!bus_a.M6800_DTACK_n || !bus_b.M6800_DTACK_n || bus_a.BUSY) seen = 1'b1;
        end
        chk_bit("abort no_dtack", seen, 1'b0);
        vpa_n = 1'b1;
        repeat (3) tick();

        // reset while DTACK is asserted
        wait_phase(0);
        vpa_n = 1'b0;
        as_n  = 1'b0;
        for (int n = 0; n < 20 && bus_a.M6800_DTACK_n; n++) tick();
        chk_bit("pre_reset dtack_a", bus_a.M6800_DTACK_n, 1'b0);
        RESET = 1'b1;
        tick();
        chk_bit("reset vma", bus_a.VMA_n, 1'b1);
        chk_bit("reset dtack", bus_a.M6800_DTACK_n, 1'b1);
        chk_bit("reset e", bus_a.E, 1'b0);
        chk_bit("reset busy", bus_a.BUSY, 1'b0);
        chk_bit("reset e_fall", bus_a.E_FALL, 1'b0);
        RESET = 1'b0;
        vpa_n = 1'b1;
        as_n  = 1'b1;
        repeat (12) tick();

        // random pin activity, occasional reset, all checked against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) vpa_n = ~vpa_n;
            if ($urandom_range(0, 15) == 0) as_n = ~as_n;
            if ($urandom_range(0, 63) == 0) cpuspace = ~cpuspace;
            RESET = ($urandom_range(0, 599) == 0);
            tick();
        end
        RESET = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
